// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU memory subsystem: arbiter state
// encoding, grant identifiers and the machine word width.
package cpu_pkg;
  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    WAIT
  } arb_state_t;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;
endpackage

// File: rtl/arb_rr2.sv
// Two-requester round-robin pick. Under contention the side that did not win
// last time is chosen; last_grant only moves when the pick is actually taken.
module arb_rr2
  import cpu_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_i,
  input  logic req_d,
  input  logic take,
  output logic grant
);
  logic last_grant;

  always_comb begin
    if (req_i && req_d) grant = ~last_grant;
    else if (req_d)     grant = GRANT_D;
    else                grant = GRANT_I;
  end

  // Fetch counts as the previous winner out of reset, so first contention goes to data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       last_grant <= GRANT_I;
    else if (take) last_grant <= grant;
  end
endmodule

// File: rtl/mem_arbiter.sv
// Shares one fixed-latency memory between fetch (I) and data (D) ports: one
// command at a time, latency counted out, one-cycle ready pulse on completion.
module mem_arbiter
  import cpu_pkg::*;
#(
  parameter int LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [WORD_W-1:0] i_addr,
  output logic              i_rdy,
  output logic [WORD_W-1:0] i_data,
  output logic              i_stall,
  input  logic              d_re,
  input  logic              d_we,
  input  logic [WORD_W-1:0] d_addr,
  input  logic [WORD_W-1:0] d_wdata,
  output logic              d_rdy,
  output logic [WORD_W-1:0] d_rdata,
  output logic              d_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata
);
  if (LAT < 1 || LAT > 15) begin : g_bad_lat
    $error("mem_arbiter: LAT must be in 1..15");
  end

  localparam logic [3:0] LAT_CNT = 4'(LAT);

  arb_state_t state;
  logic [3:0] cnt;
  logic       grant;
  logic       pick;
  logic       d_req;
  logic       take;
  logic       done;

  assign d_req = d_re | d_we;
  assign take  = (state == IDLE) && (i_req || d_req);
  assign done  = (state == WAIT) && (cnt == 4'd1);

  arb_rr2 u_rr (
    .clk   (clk),
    .rst   (rst),
    .req_i (i_req),
    .req_d (d_req),
    .take  (take),
    .grant (pick)
  );

  // Command registers double as the memory-facing outputs and hold between accesses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      grant     <= GRANT_I;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_en <= 1'b0;
      case (state)
        IDLE: begin
          if (take) begin
            grant  <= pick;
            mem_en <= 1'b1;
            state  <= CMD;
            if (pick == GRANT_D) begin
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              mem_we    <= d_we;
            end else begin
              mem_addr <= i_addr;
              mem_we   <= 1'b0;
            end
          end
        end
        CMD: begin
          cnt   <= LAT_CNT;
          state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign i_rdy   = done && (grant == GRANT_I);
  assign d_rdy   = done && (grant == GRANT_D);
  assign i_data  = i_rdy ? mem_rdata : '0;
  assign d_rdata = (d_rdy && !mem_we) ? mem_rdata : '0;
  assign i_stall = i_req & ~i_rdy;
  assign d_stall = d_req & ~d_rdy;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed access table, contention/reset sequences,
// then random traffic against a cycle-timeline reference model.
module tb_mem_arbiter;
  localparam int LAT = 2;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [15:0] i_addr;
  logic        i_rdy;
  logic [15:0] i_data;
  logic        i_stall;
  logic        d_re;
  logic        d_we;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_rdy;
  logic [15:0] d_rdata;
  logic        d_stall;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  mem_arbiter #(.LAT(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_rdy     (i_rdy),
    .i_data    (i_data),
    .i_stall   (i_stall),
    .d_re      (d_re),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdy     (d_rdy),
    .d_rdata   (d_rdata),
    .d_stall   (d_stall),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: unwritten words read as addr ^ 0xB133; read data appears LAT cycles after mem_en.
  logic [15:0] mem [256];
  bit          wr [256];
  logic [15:0] rd_pipe [LAT];

  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      mem[mem_addr[7:0]] <= mem_wdata;
      wr[mem_addr[7:0]]  <= 1'b1;
    end
    rd_pipe[0] <= (mem_en && !mem_we) ?
                  (wr[mem_addr[7:0]] ? mem[mem_addr[7:0]] : (mem_addr ^ 16'hB133)) : 16'hDEAD;
    for (int i = LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[LAT-1];

  int errors = 0;
  int checks = 0;

  task automatic chk_b(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b want %b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk_w(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    i_req = 1'b0; i_addr = 16'h0; d_re = 1'b0; d_we = 1'b0; d_addr = 16'h0; d_wdata = 16'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  typedef struct packed {
    logic        side_d;
    logic        re;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_data;
  } vec_t;

  vec_t vecs [7];

  // Called #1 after a rising edge with the DUT idle; that cycle is cycle 0.
  task automatic do_vec(input vec_t v);
    logic fin;
    if (!v.side_d) begin
      i_req = 1'b1; i_addr = v.addr;
    end else begin
      d_re = v.re; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
    end
    for (int k = 0; k <= LAT + 1; k++) begin
      @(negedge clk);
      fin = (k == LAT + 1);
      chk_b("vec_mem_en", mem_en, k == 1);
      if (k == 1) begin
        chk_w("vec_mem_addr", mem_addr, v.addr);
        chk_b("vec_mem_we", mem_we, v.side_d && v.we);
        if (v.side_d && v.we) chk_w("vec_mem_wdata", mem_wdata, v.wdata);
      end
      chk_b("vec_i_rdy", i_rdy, !v.side_d && fin);
      chk_b("vec_d_rdy", d_rdy, v.side_d && fin);
      chk_w("vec_i_data", i_data, (!v.side_d && fin) ? v.exp_data : 16'h0);
      chk_w("vec_d_rdata", d_rdata, (v.side_d && fin) ? v.exp_data : 16'h0);
      chk_b("vec_i_stall", i_stall, !v.side_d && !fin);
      chk_b("vec_d_stall", d_stall, v.side_d && !fin);
      @(posedge clk); #1;
    end
    idle_inputs();
  endtask

  // Reference model state for the random phase
  logic [15:0] ref_mem [256];
  bit          ref_wr [256];
  logic        act_i, act_d, g_d, lg, e_we;
  logic [15:0] e_addr, e_wdata, e_data;
  int          cmd_at, done_at, free_at, n_rdy;
  logic        order [$];

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    return ref_wr[a[7:0]] ? ref_mem[a[7:0]] : (a ^ 16'hB133);
  endfunction

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'hB123};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 16'h0040, 16'h5A5A, 16'h0000};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 16'h0040, 16'h0000, 16'h5A5A};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 16'h0080, 16'h1234, 16'h0000};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 16'h0080, 16'h0000, 16'h1234};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 16'h0040, 16'h0000, 16'h5A5A};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 16'h0022, 16'h0000, 16'hB111};

    // Reset state
    do_reset();
    @(negedge clk);
    chk_b("rst_mem_en", mem_en, 1'b0);
    chk_b("rst_mem_we", mem_we, 1'b0);
    chk_w("rst_mem_addr", mem_addr, 16'h0);
    chk_w("rst_mem_wdata", mem_wdata, 16'h0);
    chk_b("rst_i_rdy", i_rdy, 1'b0);
    chk_b("rst_d_rdy", d_rdy, 1'b0);
    chk_w("rst_i_data", i_data, 16'h0);
    chk_w("rst_d_rdata", d_rdata, 16'h0);
    chk_b("rst_i_stall", i_stall, 1'b0);
    chk_b("rst_d_stall", d_stall, 1'b0);
    @(posedge clk); #1;

    for (int n = 0; n < 7; n++) do_vec(vecs[n]);

    // Contention from reset: D first, then I
    do_reset();
    i_req = 1'b1; i_addr = 16'h0100; d_re = 1'b1; d_addr = 16'h0200;
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      chk_b("cont_mem_en", mem_en, k == 1 || k == 5);
      if (k == 1) chk_w("cont_addr_d", mem_addr, 16'h0200);
      if (k == 5) chk_w("cont_addr_i", mem_addr, 16'h0100);
      chk_b("cont_d_rdy", d_rdy, k == 3);
      chk_b("cont_i_rdy", i_rdy, k == 7);
      if (k == 3) chk_w("cont_d_rdata", d_rdata, 16'hB333);
      if (k == 7) chk_w("cont_i_data", i_data, 16'hB033);
      @(posedge clk); #1;
      if (k == 3) d_re = 1'b0;
      if (k == 7) i_req = 1'b0;
    end

    // Both held continuously: grants alternate D,I,D,I,D,I
    do_reset();
    i_req = 1'b1; i_addr = 16'h0300; d_re = 1'b1; d_addr = 16'h0400;
    order.delete();
    for (int k = 0; k < 40 && order.size() < 6; k++) begin
      @(negedge clk);
      if (i_rdy || d_rdy) begin
        chk_b("alt_one_rdy", i_rdy && d_rdy, 1'b0);
        chk_b("alt_timing", (k % (LAT + 2)) == (LAT + 1), 1'b1);
        order.push_back(d_rdy);
      end
      @(posedge clk); #1;
    end
    idle_inputs();
    chk_b("alt_count_6", order.size() == 6, 1'b1);
    for (int n = 0; n < order.size(); n++) chk_b("alt_order", order[n], (n % 2) == 0);
    repeat (2) @(posedge clk); #1;

    // Reset during WAIT: nothing completes, held request restarts from IDLE
    do_reset();
    i_req = 1'b1; i_addr = 16'h0010;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk_b("rstw_mem_en", mem_en, 1'b0);
    chk_b("rstw_mem_we", mem_we, 1'b0);
    chk_w("rstw_mem_addr", mem_addr, 16'h0);
    chk_b("rstw_i_rdy", i_rdy, 1'b0);
    chk_w("rstw_i_data", i_data, 16'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk_b("rstw_no_rdy", i_rdy, 1'b0);
    chk_w("rstw_no_data", i_data, 16'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k <= LAT + 1; k++) begin
      @(negedge clk);
      chk_b("rstw_re_en", mem_en, k == 1);
      if (k == 1) chk_w("rstw_re_addr", mem_addr, 16'h0010);
      chk_b("rstw_re_rdy", i_rdy, k == LAT + 1);
      chk_w("rstw_re_data", i_data, (k == LAT + 1) ? 16'hB123 : 16'h0);
      @(posedge clk); #1;
    end
    idle_inputs();

    // Random traffic against a timeline model
    do_reset();
    act_i = 1'b0; act_d = 1'b0; g_d = 1'b0; lg = 1'b0; e_we = 1'b0;
    e_addr = 16'h0; e_wdata = 16'h0; e_data = 16'h0;
    cmd_at = -1; done_at = -1; free_at = 0; n_rdy = 0;
    for (int c = 0; c < 600; c++) begin
      if (c == done_at + 1) begin
        if (g_d) act_d = 1'b0;
        else     act_i = 1'b0;
      end
      if (!act_i && $urandom_range(0, 2) == 0) begin
        act_i  = 1'b1;
        i_addr = 16'h00A0 + 16'($urandom_range(0, 15));
      end
      if (!act_d && $urandom_range(0, 2) == 0) begin
        act_d   = 1'b1;
        case ($urandom_range(0, 2))
          0:       begin d_re = 1'b1; d_we = 1'b0; end
          1:       begin d_re = 1'b0; d_we = 1'b1; end
          default: begin d_re = 1'b1; d_we = 1'b1; end
        endcase
        d_addr  = 16'h00A0 + 16'($urandom_range(0, 15));
        d_wdata = 16'($urandom);
      end
      i_req = act_i;
      if (!act_d) begin d_re = 1'b0; d_we = 1'b0; end
      if (c >= free_at && (act_i || act_d)) begin
        g_d     = act_d && (!act_i || !lg);
        lg      = g_d;
        cmd_at  = c + 1;
        done_at = c + 1 + LAT;
        free_at = c + 2 + LAT;
        e_we    = g_d && d_we;
        e_addr  = g_d ? d_addr : i_addr;
        e_wdata = d_wdata;
        if (e_we) begin
          ref_mem[e_addr[7:0]] = d_wdata;
          ref_wr[e_addr[7:0]]  = 1'b1;
          e_data = 16'h0;
        end else begin
          e_data = ref_rd(e_addr);
        end
      end
      @(negedge clk);
      chk_b("rnd_mem_en", mem_en, c == cmd_at);
      if (c == cmd_at) begin
        chk_w("rnd_mem_addr", mem_addr, e_addr);
        chk_b("rnd_mem_we", mem_we, e_we);
        if (e_we) chk_w("rnd_mem_wdata", mem_wdata, e_wdata);
      end
      chk_b("rnd_i_rdy", i_rdy, c == done_at && !g_d);
      chk_b("rnd_d_rdy", d_rdy, c == done_at && g_d);
      chk_w("rnd_i_data", i_data, (c == done_at && !g_d) ? e_data : 16'h0);
      chk_w("rnd_d_rdata", d_rdata, (c == done_at && g_d) ? e_data : 16'h0);
      chk_b("rnd_i_stall", i_stall, act_i && !(c == done_at && !g_d));
      chk_b("rnd_d_stall", d_stall, act_d && !(c == done_at && g_d));
      if (c == done_at) n_rdy++;
      @(posedge clk); #1;
    end
    idle_inputs();
    chk_b("rnd_progress", n_rdy > 50, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
